// File: rtl/coax_rx_buffer.sv
// rtl/coax_rx_buffer.sv - first-word-fall-through receive FIFO for coax words and error markers
module coax_rx_buffer #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_strobe,
  input  logic                     rx_error,
  input  logic                     rd_en,
  input  logic                     clear,
  output logic [DATA_WIDTH:0]      rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic                error_q;
  logic                overflow_q;

  logic                error_event;
  logic                push_req;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] push_entry;

  // An error edge wins over a same-cycle strobe; the data word is simply not requested.
  assign error_event = rx_error & ~error_q;
  assign push_req    = error_event | rx_strobe;
  assign push_entry  = {error_event, rx_data};

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = rd_en & ~empty;
  assign push  = push_req & (~full | pop);

  assign rd_data  = mem[rd_ptr];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Edge detector keeps sampling through clear so a held level is not re-reported.
      error_q <= rx_error;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= push_entry;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (push_req && !push) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coax_rx_buffer.sv
// tb/tb_coax_rx_buffer.sv - directed self-checking bench for coax_rx_buffer
module tb_coax_rx_buffer;

  localparam int DW    = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_strobe = 1'b0;
  logic          rx_error = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear = 1'b0;
  logic [DW:0]   rd_data;
  logic          empty;
  logic          full;
  logic [4:0]    count;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  coax_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .rx_error (rx_error),
    .rd_en    (rd_en),
    .clear    (clear),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    rx_data   = d;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic pop_word();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [DW:0] model_q[$];
  logic [DW-1:0] w;

  initial begin
    // Asynchronous reset assertion with no clock edge
    #2 reset = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    tick();
    #2 reset = 1'b1;
    tick();

    // Three words then drain
    push_word(10'h101);
    push_word(10'h2AA);
    push_word(10'h3FF);
    check_eq("t1_count", 32'(count), 3);
    check_eq("t1_head", 32'(rd_data), 32'h101);
    pop_word();
    check_eq("t1_pop1", 32'(rd_data), 32'h2AA);
    pop_word();
    check_eq("t1_pop2", 32'(rd_data), 32'h3FF);
    pop_word();
    check_eq("t1_empty", 32'(empty), 1);
    check_eq("t1_count0", 32'(count), 0);
    pop_word();
    check_eq("t1_pop_empty_count", 32'(count), 0);

    // Fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) push_word(10'(i));
    check_eq("t2_full", 32'(full), 1);
    check_eq("t2_count", 32'(count), 16);
    check_eq("t2_ovf_pre", 32'(overflow), 0);
    push_word(10'h3AB);
    check_eq("t2_ovf", 32'(overflow), 1);
    check_eq("t2_count_after", 32'(count), 16);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq($sformatf("t2_data%0d", i), 32'(rd_data), 32'(i));
      pop_word();
    end
    check_eq("t2_empty", 32'(empty), 1);
    check_eq("t2_ovf_sticky", 32'(overflow), 1);
    pulse_clear();
    check_eq("t2_ovf_cleared", 32'(overflow), 0);

    // Full with simultaneous pop and push
    for (int i = 0; i < DEPTH; i++) push_word(10'h040 + 10'(i));
    rd_en = 1'b1;
    rx_strobe = 1'b1;
    rx_data = 10'h155;
    tick();
    rd_en = 1'b0;
    rx_strobe = 1'b0;
    check_eq("t3_count", 32'(count), 16);
    check_eq("t3_ovf", 32'(overflow), 0);
    for (int i = 1; i < DEPTH; i++) begin
      check_eq($sformatf("t3_data%0d", i), 32'(rd_data), 32'h40 + 32'(i));
      pop_word();
    end
    check_eq("t3_last", 32'(rd_data), 32'h155);
    pop_word();
    check_eq("t3_empty", 32'(empty), 1);

    // Error level held 5 cycles, strobe on the first
    rx_error = 1'b1;
    rx_strobe = 1'b1;
    rx_data = 10'h0CC;
    tick();
    rx_strobe = 1'b0;
    repeat (4) tick();
    rx_error = 1'b0;
    tick();
    check_eq("t4_count", 32'(count), 1);
    check_eq("t4_entry", 32'(rd_data), 32'h4CC);
    check_eq("t4_ovf", 32'(overflow), 0);
    pop_word();
    check_eq("t4_empty", 32'(empty), 1);

    // 7 entries plus overflow, then clear with a strobe
    for (int i = 0; i < DEPTH; i++) push_word(10'h200 + 10'(i));
    push_word(10'h111);
    repeat (9) pop_word();
    check_eq("t5_count7", 32'(count), 7);
    check_eq("t5_ovf_set", 32'(overflow), 1);
    rx_strobe = 1'b1;
    rx_data = 10'h123;
    pulse_clear();
    rx_strobe = 1'b0;
    check_eq("t5_count", 32'(count), 0);
    check_eq("t5_empty", 32'(empty), 1);
    check_eq("t5_ovf", 32'(overflow), 0);
    tick();
    check_eq("t5_not_stored", 32'(count), 0);

    // Streaming with pointer wrap, async reset mid-stream
    model_q.delete();
    for (int i = 0; i < 40; i++) begin
      w = 10'((i * 37 + 5) % 1024);
      rx_data = w;
      rx_strobe = 1'b1;
      rd_en = (i % 3 != 0);
      if (rd_en && model_q.size() > 0) void'(model_q.pop_front());
      model_q.push_back({1'b0, w});
      tick();
      rx_strobe = 1'b0;
      rd_en = 1'b0;
      check_eq($sformatf("t6_count%0d", i), 32'(count), 32'(model_q.size()));
      check_eq($sformatf("t6_head%0d", i), 32'(rd_data), 32'(model_q[0]));
    end
    rx_strobe = 1'b1;
    rd_en = 1'b1;
    rx_data = 10'h3C3;
    #2 reset = 1'b0;
    #1;
    check_eq("t6_rst_count", 32'(count), 0);
    check_eq("t6_rst_empty", 32'(empty), 1);
    check_eq("t6_rst_full", 32'(full), 0);
    check_eq("t6_rst_ovf", 32'(overflow), 0);
    check_eq("t6_rst_rd_data", 32'(rd_data), 0);
    rx_strobe = 1'b0;
    rd_en = 1'b0;
    tick();
    check_eq("t6_rst_hold", 32'(count), 0);
    #2 reset = 1'b1;
    tick();
    check_eq("t6_post_idle", 32'(empty), 1);
    push_word(10'h2C3);
    check_eq("t6_post_head", 32'(rd_data), 32'h2C3);
    check_eq("t6_post_count", 32'(count), 1);
    push_word(10'h1E1);
    pop_word();
    check_eq("t6_post_second", 32'(rd_data), 32'h1E1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coax_rx_buffer.md
Name: coax_rx_buffer

Overview:
- Parametrised receive FIFO between the coax receiver and the shared data bus logic.
- Captures each received word, and each receiver error event as a tagged marker entry, into a DEPTH-deep buffer.
- Presents entries first-word-fall-through to the host side.
- Reports occupancy and overflow, and supports a synchronous flush.

Parameters:
DATA_WIDTH, 10, width of a received coax word
DEPTH, 16, number of FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock (38 MHz receive domain)
reset  input  1  asynchronous, active-low reset
rx_data  input  DATA_WIDTH  received word from receiver
rx_strobe  input  1  one-cycle pulse: rx_data valid this cycle
rx_error  input  1  receiver error level; rising edge = one error event
rd_en  input  1  pop head entry (ignored when empty)
clear  input  1  synchronous flush
rd_data  output  DATA_WIDTH+1  head entry: bit DATA_WIDTH = error tag, lower bits = word
empty  output  1  no entries
full  output  1  DEPTH entries held
count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was lost

Behaviour:
- Reset (reset low, async assert):
  - rd/wr pointers = 0; count = 0; empty = 1; full = 0; overflow = 0.
  - rx_error edge register = 0; rd_data = 0.
  - Deassertion is taken synchronously at the next clk edge.
- Storage:
  - DEPTH x (DATA_WIDTH+1) array.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate up/down counter.
  - full = (count == DEPTH); empty = (count == 0).
- Push source, one push per cycle at most:
  - Error event: rx_error high this cycle, low the previous cycle. Entry is {1'b1, rx_data}; the data bits are don't-care and written as captured.
  - Data: rx_strobe high. Entry is {1'b0, rx_data}.
  - Error event and rx_strobe in the same cycle: the error entry is pushed and the data word is discarded. overflow is not set.
- Push acceptance:
  - Accepted if !full, or if full and a pop occurs the same cycle.
  - Otherwise the push is dropped and overflow is set on the next edge.
- Pop: when rd_en and !empty, the rd pointer advances. rd_en while empty has no effect.
- Simultaneous push and pop: count unchanged.
  - When empty, the pop is ignored and the push proceeds; count becomes 1.
- rd_data (FWFT):
  - Combinationally reflects the array entry at the rd pointer.
  - Valid whenever empty = 0.
  - A word pushed at edge N is visible at rd_data, with empty = 0, after edge N.
  - Latency rx_strobe to visible = 1 cycle.
- count, full and empty are registered or derived from registered state; they update on the edge of the push/pop.
- overflow: sticky until clear or reset.
- clear:
  - Highest priority. On the edge, pointers = 0, count = 0 and overflow = 0.
  - Same-cycle push and pop are discarded.
  - The rx_error edge register still samples rx_error, so a level held through clear does not generate a new event.
- Reset mid-frame: all contents are lost. The first entry after reset must come from a fresh strobe or a fresh error edge.
- No combinational path from rd_en to full/empty/count outputs within the same cycle.

Test Plan:
- Reset, then 3 strobes with rx_data 0x101, 0x2AA, 0x3FF -> count = 3; rd_data = 0x101 with tag 0; pops return 0x2AA then 0x3FF; empty = 1 after the third pop.
- 16 strobes (DEPTH = 16), no reads -> full = 1, count = 16; a 17th strobe is dropped and overflow = 1; contents are intact 0..15 in order.
- Full buffer, rd_en plus strobe 0x155 in the same cycle -> count stays 16, overflow stays 0, 0x155 is read as the last entry.
- rx_error held high for 5 cycles with a strobe on its first cycle -> exactly one entry with tag bit 1, data word dropped, overflow = 0.
- Buffer with 7 entries and overflow = 1, pulse clear with a simultaneous strobe -> count = 0, empty = 1, overflow = 0, strobed word not stored.
- Write/read streaming over 40 words (pointer wrap twice), reset low asynchronously mid-stream -> outputs reach reset values without a clock edge; post-release data is correct from the first new strobe.
